// File: rtl/chrono_pkg.sv
// ============================================================================
// chrono_pkg : shared encodings and elaboration helpers for chrono_timebase
// Revision   : 1.0
// ============================================================================
`default_nettype none

package chrono_pkg;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    typedef enum logic {
        MODE_WRAP    = 1'b0,
        MODE_ONESHOT = 1'b1
    } mode_e;

    // Zero flags an illegal (non-integer or zero-rate) ratio for the caller to reject.
    function automatic int unsigned calc_div(input int unsigned clk_hz,
                                             input int unsigned tick_hz);
        if (tick_hz == 0 || clk_hz < tick_hz || (clk_hz % tick_hz) != 0)
            return 0;
        return clk_hz / tick_hz;
    endfunction

    function automatic int unsigned presc_width(input int unsigned div);
        return (div <= 2) ? 1 : $clog2(div);
    endfunction

endpackage

`default_nettype wire

// File: rtl/chrono_tick_gen.sv
// ============================================================================
// tick_gen : free-running prescaler producing one registered tick per DIV cycles
// Revision : 1.0
// ============================================================================
`default_nettype none

module tick_gen
    import chrono_pkg::*;
#(
    parameter int unsigned DIV = 10
) (
    input  logic CLK,
    input  logic reset,
    input  logic en,
    input  logic restart,
    output logic tick,
    output logic fire
);

    localparam int unsigned             c_PW   = presc_width(DIV);
    localparam logic [c_PW-1:0]         c_LAST = c_PW'(DIV - 1);

    logic [c_PW-1:0] presc_q, presc_d;
    logic            tick_q, tick_d;

    // fire is the pre-edge view of tick so the parent can update in lockstep.
    always_comb begin
        presc_d = presc_q;
        tick_d  = 1'b0;
        if (restart) begin
            presc_d = '0;
        end else if (en) begin
            if (presc_q == c_LAST) begin
                presc_d = '0;
                tick_d  = 1'b1;
            end else begin
                presc_d = presc_q + c_PW'(1);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!reset) begin
            presc_q <= '0;
            tick_q  <= 1'b0;
        end else begin
            presc_q <= presc_d;
            tick_q  <= tick_d;
        end
    end

    assign tick = tick_q;
    assign fire = tick_d;

endmodule

`default_nettype wire

// File: rtl/chrono_timebase.sv
// ============================================================================
// chrono_timebase : parametrised tick counter with up/down, wrap/one-shot, lap
// Revision        : 1.0
// ============================================================================
`default_nettype none

module chrono_timebase
    import chrono_pkg::*;
#(
    parameter int unsigned     CLK_HZ    = 10000,
    parameter int unsigned     TICK_HZ   = 1000,
    parameter int              COUNT_W   = 32,
    parameter longint unsigned MAX_COUNT = 10000
) (
    input  logic               CLK,
    input  logic               reset,
    input  logic               en,
    input  logic               clear,
    input  logic               load,
    input  logic [COUNT_W-1:0] load_value,
    input  logic               down,
    input  logic               oneshot,
    input  logic               lap,
    output logic [COUNT_W-1:0] count,
    output logic               tick,
    output logic               wrap,
    output logic               done,
    output logic [COUNT_W-1:0] lap_value,
    output logic               lap_valid
);

    localparam int unsigned DIV = calc_div(CLK_HZ, TICK_HZ);

    generate
        if (DIV < 1) begin : g_bad_div
            $error("chrono_timebase: CLK_HZ/TICK_HZ must be an integer >= 1");
        end
        if (MAX_COUNT < 2 ||
            (COUNT_W < 64 && MAX_COUNT > (64'd1 << COUNT_W))) begin : g_bad_max
            $error("chrono_timebase: MAX_COUNT must lie in 2..2**COUNT_W");
        end
    endgenerate

    localparam logic [COUNT_W-1:0] c_MAX_M1  = COUNT_W'(MAX_COUNT - 64'd1);
    localparam logic [COUNT_W:0]   c_MAX_EXT = {1'b0, c_MAX_M1};

    logic w_restart, w_fire;
    dir_e  w_dir;
    mode_e w_mode;

    logic [COUNT_W-1:0] count_q, count_d;
    logic               wrap_q, wrap_d;
    logic               done_q, done_d;
    logic [COUNT_W-1:0] lap_value_q, lap_value_d;
    logic               lap_valid_q, lap_valid_d;
    logic [COUNT_W-1:0] w_load_clamped;

    assign w_restart = clear | load;
    assign w_dir     = dir_e'(down);
    assign w_mode    = mode_e'(oneshot);

    tick_gen #(
        .DIV(DIV)
    ) u_tick_gen (
        .CLK     (CLK),
        .reset   (reset),
        .en      (en),
        .restart (w_restart),
        .tick    (tick),
        .fire    (w_fire)
    );

    // Compare one bit wider so MAX_COUNT = 2**COUNT_W still clamps correctly.
    assign w_load_clamped = ({1'b0, load_value} > c_MAX_EXT) ? c_MAX_M1 : load_value;

    always_comb begin
        count_d     = count_q;
        done_d      = done_q;
        wrap_d      = 1'b0;
        lap_valid_d = lap;
        lap_value_d = lap ? count_q : lap_value_q;

        if (clear) begin
            count_d = '0;
            done_d  = 1'b0;
        end else if (load) begin
            count_d = w_load_clamped;
            done_d  = 1'b0;
        end else if (w_fire && !done_q) begin
            if (w_dir == DIR_UP) begin
                if ({1'b0, count_q} >= c_MAX_EXT) begin
                    if (w_mode == MODE_ONESHOT) begin
                        done_d = 1'b1;
                    end else begin
                        count_d = '0;
                        wrap_d  = 1'b1;
                    end
                end else begin
                    count_d = count_q + COUNT_W'(1);
                end
            end else begin
                if (count_q == '0) begin
                    if (w_mode == MODE_ONESHOT) begin
                        done_d = 1'b1;
                    end else begin
                        count_d = c_MAX_M1;
                        wrap_d  = 1'b1;
                    end
                end else begin
                    count_d = count_q - COUNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!reset) begin
            count_q     <= '0;
            wrap_q      <= 1'b0;
            done_q      <= 1'b0;
            lap_value_q <= '0;
            lap_valid_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            wrap_q      <= wrap_d;
            done_q      <= done_d;
            lap_value_q <= lap_value_d;
            lap_valid_q <= lap_valid_d;
        end
    end

    assign count     = count_q;
    assign wrap      = wrap_q;
    assign done      = done_q;
    assign lap_value = lap_value_q;
    assign lap_valid = lap_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_chrono_timebase.sv
// ============================================================================
// tb_chrono_timebase : directed scoreboard bench for chrono_timebase (DIV=10, DIV=1)
// Revision           : 1.0
// ============================================================================
`default_nettype none

module tb_chrono_timebase;

    logic        CLK = 1'b0;
    logic        reset, en, clear, load, down, oneshot, lap;
    logic [31:0] load_value;

    logic [31:0] count, lap_value;
    logic        tick, wrap, done, lap_valid;
    logic [31:0] count2, lap_value2;
    logic        tick2, wrap2, done2, lap_valid2;

    chrono_timebase dut (
        .CLK(CLK), .reset(reset), .en(en), .clear(clear), .load(load),
        .load_value(load_value), .down(down), .oneshot(oneshot), .lap(lap),
        .count(count), .tick(tick), .wrap(wrap), .done(done),
        .lap_value(lap_value), .lap_valid(lap_valid)
    );

    chrono_timebase #(.CLK_HZ(1000), .TICK_HZ(1000)) dut_div1 (
        .CLK(CLK), .reset(reset), .en(en), .clear(clear), .load(load),
        .load_value(load_value), .down(down), .oneshot(oneshot), .lap(lap),
        .count(count2), .tick(tick2), .wrap(wrap2), .done(done2),
        .lap_value(lap_value2), .lap_valid(lap_valid2)
    );

    always #5 CLK = ~CLK;

    longint unsigned exp_q[$];
    int n_assert = 0;
    int n_fail   = 0;
    int n_tick, n_wrap, n_wrap_tick, first_tick, cyc;

    task automatic push(input longint unsigned v);
        exp_q.push_back(v);
    endtask

    task automatic chk(input string tag, input longint unsigned obs);
        longint unsigned e;
        n_assert++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $error("FAIL %s: observed %0d, scoreboard empty", tag, obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e) else begin
                n_fail++;
                $error("FAIL %s: observed %0d expected %0d", tag, obs, e);
            end
        end
    endtask

    task automatic zero_mon();
        n_tick = 0; n_wrap = 0; n_wrap_tick = 0; first_tick = 0; cyc = 0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK); #1;
            cyc++;
            if (tick) begin
                n_tick++;
                if (first_tick == 0) first_tick = cyc;
            end
            if (wrap) n_wrap++;
            if (wrap && tick) n_wrap_tick++;
        end
    endtask

    task automatic pulse_load(input logic [31:0] v);
        load_value = v; load = 1'b1;
        run(1);
        load = 1'b0;
    endtask

    initial begin
        reset = 1'b0; en = 1'b0; clear = 1'b0; load = 1'b0;
        down = 1'b0; oneshot = 1'b0; lap = 1'b0; load_value = '0;
        zero_mon();
        run(2);
        push(0); push(0); push(0); push(0); push(0); push(0);
        chk("rst_count", count);  chk("rst_tick", tick);   chk("rst_wrap", wrap);
        chk("rst_done", done);    chk("rst_lapv", lap_value); chk("rst_lapvld", lap_valid);

        // Free run for 100 cycles
        reset = 1'b1; en = 1'b1;
        push(10); push(10); push(10); push(0);
        zero_mon(); run(100);
        chk("run_ticks", n_tick); chk("run_first", first_tick);
        chk("run_count", count);  chk("run_wrap", n_wrap);

        // Up wrap from MAX-1
        pulse_load(32'd9999);
        push(1); push(1); push(0); push(0);
        zero_mon(); run(10);
        chk("wrap_n", n_wrap); chk("wrap_with_tick", n_wrap_tick);
        chk("wrap_count", count); chk("wrap_done", done);

        // One-shot up stop
        oneshot = 1'b1;
        pulse_load(32'd9998);
        push(9999); push(1); push(0);
        run(10);
        chk("os_count1", count); chk("os_tick1", tick); chk("os_done1", done);
        push(4); push(9999); push(1); push(0);
        zero_mon(); run(40);
        chk("os_ticks", n_tick); chk("os_count", count); chk("os_done", done);
        chk("os_wrap", n_wrap);
        clear = 1'b1; push(0); push(0); push(0);
        run(1); clear = 1'b0;
        chk("clr_count", count); chk("clr_done", done); chk("clr_tick", tick);

        // Down wrap from 0, then clamp on load
        oneshot = 1'b0; down = 1'b1;
        pulse_load(32'd0);
        push(9999); push(1); push(1);
        run(10);
        chk("dn_count", count); chk("dn_wrap", wrap); chk("dn_tick", tick);
        pulse_load(32'd20000);
        push(9999);
        chk("clamp_count", count);

        // Pause mid-period, resume, then lap
        down = 1'b0;
        clear = 1'b1; run(1); clear = 1'b0;
        run(55);
        en = 1'b0;
        push(0); push(5);
        zero_mon(); run(50);
        chk("pause_ticks", n_tick); chk("pause_count", count);
        en = 1'b1;
        push(5); push(6);
        zero_mon(); run(5);
        chk("resume_first", first_tick); chk("resume_count", count);
        lap = 1'b1; run(1); lap = 1'b0;
        push(1); push(6);
        chk("lap_valid", lap_valid); chk("lap_value", lap_value);
        run(1);
        push(0); push(6);
        chk("lap_valid_drop", lap_valid); chk("lap_value_hold", lap_value);

        // clear+load on an edge that would have ticked
        run(7);
        clear = 1'b1; load = 1'b1; load_value = 32'd77;
        run(1);
        clear = 1'b0; load = 1'b0;
        push(0); push(0); push(0);
        chk("cl_count", count); chk("cl_tick", tick); chk("cl_wrap", wrap);

        // Reset mid-run with a lap pending
        lap = 1'b1; run(13);
        reset = 1'b0; run(1);
        push(0); push(0); push(0); push(0); push(0);
        chk("mrst_count", count); chk("mrst_tick", tick); chk("mrst_lapv", lap_value);
        chk("mrst_lapvld", lap_valid); chk("mrst_done", done);
        reset = 1'b1; lap = 1'b0;

        // DIV = 1 instance
        clear = 1'b1; run(1); clear = 1'b0;
        push(1); push(1);
        run(1);
        chk("d1_count1", count2); chk("d1_tick1", tick2);
        push(2);
        run(1);
        chk("d1_count2", count2);
        push(7);
        run(5);
        chk("d1_count7", count2);
        en = 1'b0;
        push(7); push(0);
        run(1);
        chk("d1_hold", count2); chk("d1_notick", tick2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
